// File: rtl/led_frame_arbiter.sv
// Frame arbiter for the LED matrix driver: picks one of three frame sources at each FRAME_TICK edge.
// Decision and capture land on the tick edge; FRAME_LOAD pulses the cycle after. No backpressure.
module led_frame_arbiter #(
    parameter int HOLD_FRAMES = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    FRAME_TICK,
    input  logic [2:0]              REQ,
    input  logic [2:0][15:0][15:0]  SrcRed,
    input  logic [2:0][15:0][15:0]  SrcGrn,
    output logic [15:0][15:0]       RedPixels,
    output logic [15:0][15:0]       GrnPixels,
    output logic [2:0]              GNT,
    output logic                    FRAME_LOAD
);

    localparam int HCW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(HOLD_FRAMES);
    localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t         state;
    logic [1:0]     owner;
    logic [HCW-1:0] hold_cnt;

    state_t         nxt_state;
    logic [1:0]     nxt_owner;
    logic [HCW-1:0] nxt_hold;
    logic [2:0]     higher;

    // Index of the highest-priority (lowest-numbered) set bit; caller guarantees r != 0.
    function automatic logic [1:0] pick(input logic [2:0] r);
        if (r[0])      return 2'd0;
        else if (r[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    always_comb begin
        higher = 3'b000;
        case (owner)
            2'd1:    higher = 3'b001;
            2'd2:    higher = 3'b011;
            default: higher = 3'b000;
        endcase
    end

    always_comb begin
        nxt_state = IDLE;
        nxt_owner = 2'd0;
        nxt_hold  = '0;
        if (state == IDLE || !REQ[owner]) begin
            // Fresh grant: idle start or the current owner dropped its request.
            if (|REQ) begin
                nxt_state = OWN;
                nxt_owner = pick(REQ);
                nxt_hold  = HOLD_ONE;
            end
        end else if (hold_cnt < HOLD_MAX) begin
            nxt_state = OWN;
            nxt_owner = owner;
            nxt_hold  = hold_cnt + HOLD_ONE;
        end else if (|(REQ & higher)) begin
            nxt_state = OWN;
            nxt_owner = pick(REQ & higher);
            nxt_hold  = HOLD_ONE;
        end else begin
            nxt_state = OWN;
            nxt_owner = owner;
            nxt_hold  = hold_cnt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            owner      <= 2'd0;
            hold_cnt   <= '0;
            RedPixels  <= '0;
            GrnPixels  <= '0;
            GNT        <= 3'b000;
            FRAME_LOAD <= 1'b0;
        end else begin
            FRAME_LOAD <= FRAME_TICK;
            if (FRAME_TICK) begin
                state    <= nxt_state;
                owner    <= nxt_owner;
                hold_cnt <= nxt_hold;
                if (nxt_state == OWN) begin
                    RedPixels <= SrcRed[nxt_owner];
                    GrnPixels <= SrcGrn[nxt_owner];
                    GNT       <= 3'b001 << nxt_owner;
                end else begin
                    RedPixels <= '0;
                    GrnPixels <= '0;
                    GNT       <= 3'b000;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Scoreboard bench: two arbiters (HOLD_FRAMES 4 and 1) share stimulus; a frame-level model
// pushes the expected owner/frame per tick and a monitor compares every cycle.
module tb_led_frame_arbiter;

    typedef struct packed {
        logic [2:0]         gnt;
        logic [15:0][15:0]  red;
        logic [15:0][15:0]  grn;
    } exp_t;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b0;
    logic                   FRAME_TICK = 1'b0;
    logic [2:0]             REQ = 3'b000;
    logic [2:0][15:0][15:0] src_red = '0;
    logic [2:0][15:0][15:0] src_grn = '0;

    logic [15:0][15:0] red4, grn4, red1, grn1;
    logic [2:0]        gnt4, gnt1;
    logic              ld4, ld1;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t cur[2];
    int   m_own[2]  = '{-1, -1};
    int   m_hold[2] = '{0, 0};
    int   m_lim[2]  = '{4, 1};

    led_frame_arbiter #(.HOLD_FRAMES(4)) u4 (
        .CLK(CLK), .RST(RST), .FRAME_TICK(FRAME_TICK), .REQ(REQ),
        .SrcRed(src_red), .SrcGrn(src_grn),
        .RedPixels(red4), .GrnPixels(grn4), .GNT(gnt4), .FRAME_LOAD(ld4)
    );

    led_frame_arbiter #(.HOLD_FRAMES(1)) u1 (
        .CLK(CLK), .RST(RST), .FRAME_TICK(FRAME_TICK), .REQ(REQ),
        .SrcRed(src_red), .SrcGrn(src_grn),
        .RedPixels(red1), .GrnPixels(grn1), .GNT(gnt1), .FRAME_LOAD(ld1)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic scramble();
        for (int s = 0; s < 3; s++)
            for (int r = 0; r < 16; r++) begin
                src_red[s][r] = 16'($urandom);
                src_grn[s][r] = 16'($urandom);
            end
    endtask

    // Frame-level reference: owner as an integer (-1 = idle), rules applied directly.
    task automatic model_step(input logic [2:0] r);
        int   top;
        exp_t e;
        top = -1;
        for (int b = 2; b >= 0; b--) if (r[b]) top = b;
        for (int i = 0; i < 2; i++) begin
            if (m_own[i] < 0 || !r[m_own[i]]) begin
                m_own[i]  = top;
                m_hold[i] = (top < 0) ? 0 : 1;
            end else if (m_hold[i] < m_lim[i]) begin
                m_hold[i]++;
            end else if (top < m_own[i]) begin
                m_own[i]  = top;
                m_hold[i] = 1;
            end
            if (m_own[i] < 0) begin
                e = '0;
            end else begin
                e.gnt = 3'(1 << m_own[i]);
                e.red = src_red[m_own[i]];
                e.grn = src_grn[m_own[i]];
            end
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic model_reset();
        m_own  = '{-1, -1};
        m_hold = '{0, 0};
    endtask

    // One frame tick; inputs and pixel data are scrambled afterwards to show they are not sampled.
    task automatic tick(input logic [2:0] r, input int gap);
        @(negedge CLK);
        REQ = r;
        FRAME_TICK = 1'b1;
        if (RST) model_step(r);
        @(negedge CLK);
        FRAME_TICK = 1'b0;
        REQ = 3'($urandom);
        scramble();
        repeat (gap) @(negedge CLK);
    endtask

    task automatic mon_dut(input int i, input logic tk, input logic [2:0] gnt,
                           input logic [15:0][15:0] red, input logic [15:0][15:0] grn,
                           input logic ld);
        string nm;
        nm = (i == 0) ? "h4" : "h1";
        if (!RST) begin
            cur[i] = '0;
        end else if (tk) begin
            if (i == 0 && q0.size() == 0 || i == 1 && q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s_queue_underflow act=empty exp=entry", nm);
            end else if (i == 0) cur[i] = q0.pop_front();
            else                 cur[i] = q1.pop_front();
        end
        chk({nm, "_frame_load"}, 512'(ld), 512'(tk));
        chk({nm, "_gnt"}, 512'(gnt), 512'(cur[i].gnt));
        chk({nm, "_red"}, 512'(red), 512'(cur[i].red));
        chk({nm, "_grn"}, 512'(grn), 512'(cur[i].grn));
    endtask

    always @(posedge CLK) begin
        logic tk;
        tk = FRAME_TICK & RST;
        #1;
        mon_dut(0, tk, gnt4, red4, grn4, ld4);
        mon_dut(1, tk, gnt1, red1, grn1, ld1);
    end

    initial begin
        logic [15:0][15:0] pat;

        scramble();
        // Reset held while ticking with every source requesting.
        repeat (2) tick(3'b111, 1);
        chk("rst_gnt", 512'(gnt4), 512'(3'b000));
        chk("rst_red", 512'(red4), 512'(0));
        chk("rst_load", 512'(ld4), 512'(0));
        @(negedge CLK);
        RST = 1'b1;

        tick(3'b000, 0);
        chk("idle_gnt", 512'(gnt4), 512'(3'b000));

        // Simple grant with a known green pattern on source 2.
        for (int r = 0; r < 16; r++) pat[r] = 16'h52AA;
        src_grn[2] = pat;
        tick(3'b100, 3);
        chk("grant2_gnt", 512'(gnt4), 512'(3'b100));
        chk("grant2_grn", 512'(grn4), 512'(pat));

        // Minimum hold: source 1 must wait until source 2 has held 4 frames.
        repeat (3) tick(3'b110, 0);
        chk("hold_keep_gnt", 512'(gnt4), 512'(3'b100));
        chk("hold1_gnt", 512'(gnt1), 512'(3'b010));
        tick(3'b110, 1);
        chk("hold_preempt_gnt", 512'(gnt4), 512'(3'b010));

        // Owner drop hands over immediately, then to idle.
        tick(3'b100, 0);
        chk("drop_gnt", 512'(gnt4), 512'(3'b100));
        tick(3'b000, 1);
        chk("drop_idle_gnt", 512'(gnt4), 512'(3'b000));
        chk("drop_idle_red", 512'(red4), 512'(0));

        // Priority tie from idle, then HOLD_FRAMES=1 reselects every frame.
        tick(3'b111, 0);
        chk("tie_gnt", 512'(gnt4), 512'(3'b001));
        tick(3'b110, 0);
        chk("tie_next_gnt1", 512'(gnt1), 512'(3'b010));

        // Asynchronous reset between clock edges.
        tick(3'b010, 2);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        chk("arst_gnt", 512'(gnt4), 512'(3'b000));
        chk("arst_red", 512'(red4), 512'(0));
        chk("arst_grn", 512'(grn1), 512'(0));
        chk("arst_load", 512'(ld4), 512'(0));
        model_reset();
        tick(3'b111, 0);
        @(negedge CLK);
        RST = 1'b1;
        tick(3'b010, 0);
        chk("arst_regrant_gnt", 512'(gnt4), 512'(3'b010));
        repeat (4) tick(3'b011, 0);
        chk("arst_hold_restart", 512'(gnt4), 512'(3'b001));

        // Random frames, including back-to-back ticks.
        for (int n = 0; n < 400; n++) tick(3'($urandom), $urandom_range(0, 2));

        repeat (3) @(negedge CLK);
        chk("q_drained", 512'(q0.size() + q1.size()), 512'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
